mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4: memory read latency in cycles, legal 1..15.
REQ-002 SHALL have parameter ADDR_W, default 16: address width.
REQ-003 SHALL have parameter DATA_W, default 16: data width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports i_req/d_req  input  1  I-cache/D-cache miss request, held until matching done.
REQ-007 SHALL have ports i_addr/d_addr  input  ADDR_W  request addresses; i_wr/d_wr input 1 write flag (i_wr always 0 in normal use); d_wdata input DATA_W.
REQ-008 SHALL have ports i_done/d_done  output  1  one-cycle completion pulse per granted transaction.
REQ-009 SHALL have ports i_rdata/d_rdata  output  DATA_W  read data, valid while the matching done is high.
REQ-010 SHALL have ports mem_en, mem_wr  output 1; mem_addr output ADDR_W; mem_wdata output DATA_W: shared-memory command.
REQ-011 SHALL have ports mem_stall input 1 (memory refuses command this cycle) and mem_rdata input DATA_W.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: on an edge with any req high, SHALL latch owner, addr, wr and wdata, then go to ISSUE; with no req, SHALL stay in IDLE.
REQ-015 Arbitration: both reqs high in the same cycle SHALL grant D (fixed D-priority, unless changed by REQ-026).
REQ-016 ISSUE: SHALL drive mem_en=1 with the latched command; mem_stall=1 SHALL hold ISSUE and keep the command stable; mem_stall=0 SHALL load the counter with MEM_LAT-1 and go to WAIT.
REQ-017 WAIT: SHALL decrement the counter each cycle; at 0 SHALL capture mem_rdata (reads only) and go to RESP. mem_rdata is therefore sampled exactly MEM_LAT edges after the accepting issue edge.
REQ-018 RESP: SHALL pulse the owner's done for exactly one cycle, then return to IDLE; a waiting requester SHALL be granted at the next IDLE edge.
REQ-019 Writes SHALL follow the same timing; for writes, rdata SHALL keep its previous value.
REQ-020 Deasserting req after grant SHALL NOT abort the transaction; done SHALL still pulse.
REQ-021 Address or data changes on a requester after the grant SHALL be ignored (latched copy used).
REQ-022 mem_en SHALL be 0 in every state except ISSUE; never more than one transaction SHALL be outstanding.
REQ-023 Counter SHALL be 4 bits; MEM_LAT=1 SHALL give one WAIT cycle.

Reset
REQ-024 rst low SHALL immediately force IDLE, counter 0, and every output low or 0 (done, mem_en, mem_wr, mem_addr, mem_wdata, rdata, busy), regardless of clk.
REQ-025 Reset mid-transaction SHALL drop the transaction with no done pulse; the requester must re-request.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, SHALL use round-robin arbitration: on a tie, grant the requester not served last (last-owner flop, reset to I so D wins the first tie); without it, SHALL use fixed D-priority.

Structure
REQ-027 SHALL place the state enum and owner encoding (OWN_I=0, OWN_D=1) in shared package mem_arb_pkg.
REQ-028 SHALL place the latency down-counter in sub-module mem_arb_cnt (load, decrement, zero flag).

Verification
REQ-029 Single I read, addr 0x0040, MEM_LAT=4, no stall: mem_en one cycle, then i_done exactly 5 cycles after the issue edge with i_rdata equal to the memory model value.
REQ-030 i_req and d_req rise in the same cycle: D served first; I issued at the IDLE edge after d_done; no cycle with mem_en high for both. With MEM_ARB_RR_EN, a second tie grants I.
REQ-031 D write, addr 0x1234, data 0xBEEF, mem_stall held 3 cycles: mem_en high for 4 cycles with a stable command; d_done 4 cycles after release; d_rdata unchanged.
REQ-032 Reset asserted during WAIT: outputs zero asynchronously, no done pulse, FSM in IDLE; a new request after reset completes normally.
REQ-033 d_req dropped and d_addr changed one cycle after grant: memory sees the original address; d_done still pulses once.
REQ-034 MEM_LAT=1, back-to-back I requests: each completes 2 cycles after issue; busy low for exactly one cycle between transactions.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, owner encoding,
// latency counter width. MEM_ARB_RR_EN selects round-robin tie-breaking in mem_arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arb_cnt.sv
// Memory-latency down-counter: loads MEM_LAT-1 on command acceptance and
// counts down while the arbiter waits; o_zero marks the read-data sample cycle.
module mem_arb_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for one shared fixed-latency memory.
// Fixed D-priority by default; define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  state_t            r_state, w_next;
  owner_t            r_own, w_grant_own;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata, r_i_rdata, r_d_rdata;
  logic              w_grant, w_issue, w_cnt_load, w_cnt_dec, w_cnt_zero, w_capture;

`ifdef MEM_ARB_RR_EN
  owner_t r_last_own;

  // On a tie, serve whoever did not win the previous grant.
  always_comb begin
    if (i_req && d_req) w_grant_own = other_owner(r_last_own);
    else if (d_req)     w_grant_own = OWN_D;
    else                w_grant_own = OWN_I;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_last_own <= OWN_I;
    else if (w_grant) r_last_own <= w_grant_own;
  end
`else
  assign w_grant_own = d_req ? OWN_D : OWN_I;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_issue    = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          w_grant = 1'b1;
          w_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue = 1'b1;
        if (!mem_stall) begin
          w_cnt_load = 1'b1;
          w_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero) begin
          w_capture = 1'b1;
          w_next    = ST_RESP;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Command is latched at grant so requester-side changes afterwards are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_own     <= OWN_I;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_own   <= w_grant_own;
        r_addr  <= (w_grant_own == OWN_D) ? d_addr : i_addr;
        r_wr    <= (w_grant_own == OWN_D) ? d_wr : i_wr;
        r_wdata <= (w_grant_own == OWN_D) ? d_wdata : '0;
      end
      if (w_capture && !r_wr) begin
        if (r_own == OWN_D) r_d_rdata <= mem_rdata;
        else                r_i_rdata <= mem_rdata;
      end
    end
  end

  mem_arb_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  assign mem_en    = w_issue;
  assign mem_wr    = w_issue & r_wr;
  assign mem_addr  = w_issue ? r_addr : '0;
  assign mem_wdata = w_issue ? r_wdata : '0;
  assign busy      = (r_state != ST_IDLE);
  assign i_done    = (r_state == ST_RESP) && (r_own == OWN_I);
  assign d_done    = (r_state == ST_RESP) && (r_own == OWN_D);
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
